// File: rtl/vga_grid_renderer_pkg.sv
// Constants shared by the grid renderer and the game logic: block codes,
// palette, grid defaults and 640x480@60 raster timing.
package vga_grid_renderer_pkg;

  localparam int BITS_PER_BLOCK = 3;

  typedef enum logic [BITS_PER_BLOCK-1:0] {
    BLOCK_EMPTY = 3'd0,
    BLOCK_WALL  = 3'd1,
    BLOCK_SNAKE = 3'd2,
    BLOCK_FOOD  = 3'd3
  } block_e;

  localparam int GRID_WIDTH  = 40;
  localparam int GRID_HEIGHT = 30;

  typedef logic [7:0] rgb_t;

  localparam rgb_t COLOR_EMPTY = 8'h00;
  localparam rgb_t COLOR_WALL  = 8'h92;
  localparam rgb_t COLOR_SNAKE = 8'h1C;
  localparam rgb_t COLOR_FOOD  = 8'hE0;
  localparam rgb_t COLOR_BAD   = 8'hE3;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_TOTAL   = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_TOTAL   = 525;

  // Unused codes render magenta so a corrupted grid cell is obvious on screen.
  function automatic rgb_t block_color(input logic [BITS_PER_BLOCK-1:0] code);
    rgb_t c;
    case (code)
      BLOCK_EMPTY: c = COLOR_EMPTY;
      BLOCK_WALL:  c = COLOR_WALL;
      BLOCK_SNAKE: c = COLOR_SNAKE;
      BLOCK_FOOD:  c = COLOR_FOOD;
      default:     c = COLOR_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_grid_renderer_if.sv
// Synchronous read port into the game grid: the renderer drives the block
// address, the memory returns the block code one Clock later.
interface vga_grid_renderer_if #(
  parameter int GRID_WIDTH     = vga_grid_renderer_pkg::GRID_WIDTH,
  parameter int GRID_HEIGHT    = vga_grid_renderer_pkg::GRID_HEIGHT,
  parameter int BITS_PER_BLOCK = vga_grid_renderer_pkg::BITS_PER_BLOCK
);
  logic [$clog2(GRID_HEIGHT)-1:0] GridAddrV;
  logic [$clog2(GRID_WIDTH)-1:0]  GridAddrH;
  logic [BITS_PER_BLOCK-1:0]      GridData;

  modport master (output GridAddrV, output GridAddrH, input GridData);
  modport slave  (input GridAddrV, input GridAddrH, output GridData);
endinterface

// File: rtl/vga_timing.sv
// Pixel-tick divider plus horizontal/vertical raster counters (stage 0).
// Sync, visible and frame-start flags decode straight from the registered counters.
module vga_timing #(
  parameter int CLKS_PER_PIXEL = 4,
  parameter int H_VISIBLE = vga_grid_renderer_pkg::H_VISIBLE,
  parameter int H_FP      = vga_grid_renderer_pkg::H_FP,
  parameter int H_SYNC    = vga_grid_renderer_pkg::H_SYNC,
  parameter int H_TOTAL   = vga_grid_renderer_pkg::H_TOTAL,
  parameter int V_VISIBLE = vga_grid_renderer_pkg::V_VISIBLE,
  parameter int V_FP      = vga_grid_renderer_pkg::V_FP,
  parameter int V_SYNC    = vga_grid_renderer_pkg::V_SYNC,
  parameter int V_TOTAL   = vga_grid_renderer_pkg::V_TOTAL,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL),
  localparam int DW = $clog2(CLKS_PER_PIXEL)
) (
  input  logic          Clock,
  input  logic          Reset,
  output logic          tick_o,
  output logic [HW-1:0] hcount_o,
  output logic [VW-1:0] vcount_o,
  output logic          visible_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          frame_start_o
);
  import vga_grid_renderer_pkg::*;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_PIXEL - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d    = tick ? '0 : div_q + 1'b1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (tick) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign tick_o    = tick;
  assign hcount_o  = hcount_q;
  assign vcount_o  = vcount_q;
  assign visible_o = (hcount_q < HW'(H_VISIBLE)) && (vcount_q < VW'(V_VISIBLE));
  assign hsync_o   = !((hcount_q >= HS_BEGIN) && (hcount_q < HS_END));
  assign vsync_o   = !((vcount_q >= VS_BEGIN) && (vcount_q < VS_END));
  // The tick that carries the raster onto the first blanking line.
  assign frame_start_o = tick && (hcount_q == H_LAST) && (vcount_q == VW'(V_VISIBLE - 1));

endmodule

// File: rtl/vga_grid_renderer.sv
// Reads one block code per pixel from the grid and drives RRRGGGBB colour plus
// syncs, all two pixel ticks behind the raster counters; FrameStart is undelayed.
module vga_grid_renderer #(
  parameter int CLKS_PER_PIXEL = 4,
  parameter int BLOCK_PX_LOG2  = 4,
  parameter int GRID_WIDTH     = vga_grid_renderer_pkg::GRID_WIDTH,
  parameter int GRID_HEIGHT    = vga_grid_renderer_pkg::GRID_HEIGHT,
  parameter int H_VISIBLE = vga_grid_renderer_pkg::H_VISIBLE,
  parameter int H_FP      = vga_grid_renderer_pkg::H_FP,
  parameter int H_SYNC    = vga_grid_renderer_pkg::H_SYNC,
  parameter int H_TOTAL   = vga_grid_renderer_pkg::H_TOTAL,
  parameter int V_VISIBLE = vga_grid_renderer_pkg::V_VISIBLE,
  parameter int V_FP      = vga_grid_renderer_pkg::V_FP,
  parameter int V_SYNC    = vga_grid_renderer_pkg::V_SYNC,
  parameter int V_TOTAL   = vga_grid_renderer_pkg::V_TOTAL
) (
  input  logic                       Clock,
  input  logic                       Reset,
  vga_grid_renderer_if.master        grid,
  output logic [7:0]                 RGB,
  output logic                       HSync,
  output logic                       VSync,
  output logic                       FrameStart
);
  import vga_grid_renderer_pkg::*;

  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int AHW = $clog2(GRID_WIDTH);
  localparam int AVW = $clog2(GRID_HEIGHT);

  logic          tick;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          visible, hsync_raw, vsync_raw;

  vga_timing #(
    .CLKS_PER_PIXEL (CLKS_PER_PIXEL),
    .H_VISIBLE (H_VISIBLE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_TOTAL (H_TOTAL),
    .V_VISIBLE (V_VISIBLE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_TOTAL (V_TOTAL)
  ) u_timing (
    .Clock         (Clock),
    .Reset         (Reset),
    .tick_o        (tick),
    .hcount_o      (hcount),
    .vcount_o      (vcount),
    .visible_o     (visible),
    .hsync_o       (hsync_raw),
    .vsync_o       (vsync_raw),
    .frame_start_o (FrameStart)
  );

  logic [AHW-1:0] addr_h_q, addr_h_d;
  logic [AVW-1:0] addr_v_q, addr_v_d;
  logic           vis1_q, vis1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  rgb_t           rgb_q, rgb_d;
  logic           hs2_q, hs2_d, vs2_q, vs2_d;

  always_comb begin
    addr_h_d = addr_h_q;
    addr_v_d = addr_v_q;
    vis1_d   = vis1_q;
    hs1_d    = hs1_q;
    vs1_d    = vs1_q;
    rgb_d    = rgb_q;
    hs2_d    = hs2_q;
    vs2_d    = vs2_q;
    if (tick) begin
      // Blanking addresses park at 0 so the memory never sees an out-of-grid index.
      addr_h_d = visible ? AHW'(hcount >> BLOCK_PX_LOG2) : '0;
      addr_v_d = visible ? AVW'(vcount >> BLOCK_PX_LOG2) : '0;
      vis1_d   = visible;
      hs1_d    = hsync_raw;
      vs1_d    = vsync_raw;
      // GridData settled one Clock after stage 1 moved, well before this tick.
      rgb_d    = vis1_q ? block_color(grid.GridData) : COLOR_EMPTY;
      hs2_d    = hs1_q;
      vs2_d    = vs1_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      addr_h_q <= '0;
      addr_v_q <= '0;
      vis1_q   <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      rgb_q    <= COLOR_EMPTY;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
    end else begin
      addr_h_q <= addr_h_d;
      addr_v_q <= addr_v_d;
      vis1_q   <= vis1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      rgb_q    <= rgb_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
    end
  end

  assign grid.GridAddrH = addr_h_q;
  assign grid.GridAddrV = addr_v_q;
  assign RGB            = rgb_q;
  assign HSync          = hs2_q;
  assign VSync          = vs2_q;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Bench: full-size instance for reset and the first raster line, plus a shrunken
// raster instance (80x60 visible, 2 px blocks) so whole frames fit in a short run.
module tb_vga_grid_renderer;
  import vga_grid_renderer_pkg::*;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic [7:0] rgb_a, rgb_b;
  logic       hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;

  vga_grid_renderer_if gif_a ();
  vga_grid_renderer_if gif_b ();

  vga_grid_renderer u_a (
    .Clock (Clock), .Reset (rst_a), .grid (gif_a),
    .RGB (rgb_a), .HSync (hs_a), .VSync (vs_a), .FrameStart (fs_a)
  );

  vga_grid_renderer #(
    .CLKS_PER_PIXEL (2), .BLOCK_PX_LOG2 (1),
    .H_VISIBLE (80), .H_FP (4), .H_SYNC (8), .H_TOTAL (100),
    .V_VISIBLE (60), .V_FP (2), .V_SYNC (2), .V_TOTAL (66)
  ) u_b (
    .Clock (Clock), .Reset (rst_b), .grid (gif_b),
    .RGB (rgb_b), .HSync (hs_b), .VSync (vs_b), .FrameStart (fs_b)
  );

  // Grid storage model with a one-Clock synchronous read per instance.
  logic [2:0] mem [30][40];
  always @(posedge Clock) begin
    gif_a.GridData <= mem[gif_a.GridAddrV][gif_a.GridAddrH];
    gif_b.GridData <= mem[gif_b.GridAddrV][gif_b.GridAddrH];
  end

  logic       sel = 1'b0;
  logic [7:0] o_rgb;
  logic       o_hs, o_vs, o_fs;
  logic [5:0] o_ah;
  logic [4:0] o_av;
  assign o_rgb = sel ? rgb_b : rgb_a;
  assign o_hs  = sel ? hs_b : hs_a;
  assign o_vs  = sel ? vs_b : vs_a;
  assign o_fs  = sel ? fs_b : fs_a;
  assign o_ah  = sel ? gif_b.GridAddrH : gif_a.GridAddrH;
  assign o_av  = sel ? gif_b.GridAddrV : gif_a.GridAddrV;

  int cpp, blk, hvis, hfp, hsw, ht, vvis, vfp, vsw, vt;
  int vectors = 0, miscompares = 0;

  int         errs, fs_cnt, fs_first, fs_second, hs_first_low, hs_falls, vs_low;
  string      first_err;
  logic [7:0] probe [4];

  task automatic use_cfg(input bit b);
    sel = b;
    if (!b) begin
      cpp = 4; blk = 4; hvis = 640; hfp = 16; hsw = 96; ht = 800;
      vvis = 480; vfp = 10; vsw = 2; vt = 525;
    end else begin
      cpp = 2; blk = 1; hvis = 80; hfp = 4; hsw = 8; ht = 100;
      vvis = 60; vfp = 2; vsw = 2; vt = 66;
    end
  endtask

  function automatic logic [7:0] exp_rgb(input int h, input int v);
    if (h >= hvis || v >= vvis) return 8'h00;
    case (mem[v >> blk][h >> blk])
      3'd0:    return 8'h00;
      3'd1:    return 8'h92;
      3'd2:    return 8'h1C;
      3'd3:    return 8'hE0;
      default: return 8'hE3;
    endcase
  endfunction

  // Call at #1 after the edge on which reset was released; c counts Clocks since.
  task automatic scan(input int ncyc, input int ph, input int pv, input bit do_swap);
    int k, n, m, h, v, h1, v1;
    logic [7:0] e_rgb;
    logic e_hs, e_vs, e_fs, prev_hs;
    logic [5:0] e_ah;
    logic [4:0] e_av;
    errs = 0; first_err = ""; fs_cnt = 0; fs_first = -1; fs_second = -1;
    hs_first_low = -1; hs_falls = 0; vs_low = 0; prev_hs = 1'b1;
    for (int i = 0; i < 4; i++) probe[i] = 8'hxx;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge Clock); #1;
      k = c / cpp; n = k - 2; m = k - 1;
      e_rgb = 8'h00; e_hs = 1'b1; e_vs = 1'b1; e_ah = '0; e_av = '0;
      if (n >= 0) begin
        h = n % ht; v = (n / ht) % vt;
        e_rgb = exp_rgb(h, v);
        e_hs  = !(h >= hvis + hfp && h < hvis + hfp + hsw);
        e_vs  = !(v >= vvis + vfp && v < vvis + vfp + vsw);
        if (h == ph && v == pv && n / (ht * vt) < 4) probe[n / (ht * vt)] = o_rgb;
      end
      if (m >= 0) begin
        h1 = m % ht; v1 = (m / ht) % vt;
        if (h1 < hvis && v1 < vvis) begin
          e_ah = 6'(h1 >> blk); e_av = 5'(v1 >> blk);
        end
      end
      e_fs = (c % cpp == cpp - 1) && (k % ht == ht - 1) && ((k / ht) % vt == vvis - 1);
      if (o_rgb !== e_rgb || o_hs !== e_hs || o_vs !== e_vs || o_fs !== e_fs ||
          o_ah !== e_ah || o_av !== e_av) begin
        errs++;
        if (errs == 1)
          first_err = $sformatf("c=%0d rgb=%h want %h hs=%b want %b vs=%b want %b fs=%b want %b ah=%0d want %0d av=%0d want %0d",
                                c, o_rgb, e_rgb, o_hs, e_hs, o_vs, e_vs, o_fs, e_fs, o_ah, e_ah, o_av, e_av);
      end
      if (hs_first_low < 0 && o_hs === 1'b0) hs_first_low = c;
      if (fs_first >= 0 && fs_second < 0) begin
        if (prev_hs === 1'b1 && o_hs === 1'b0) hs_falls++;
        if (o_vs === 1'b0) vs_low++;
      end
      prev_hs = o_hs;
      if (o_fs === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = c;
        else if (fs_second < 0) fs_second = c;
        if (do_swap && fs_cnt == 1) mem[5][10] = BLOCK_FOOD;
      end
    end
  endtask

  task automatic test_reset();
    use_cfg(1'b0);
    rst_a = 1'b1; rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      vectors++;
      if ({rgb_a, hs_a, vs_a, fs_a} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: rgb=%h hs=%b vs=%b fs=%b, want 00 1 1 0", i, rgb_a, hs_a, vs_a, fs_a);
      end
      vectors++;
      if (gif_a.GridAddrH !== 6'd0 || gif_a.GridAddrV !== 5'd0) begin
        miscompares++;
        $display("FAIL reset_addr cycle %0d: h=%0d v=%0d, want 0 0", i, gif_a.GridAddrH, gif_a.GridAddrV);
      end
    end
    rst_a = 1'b0;
  endtask

  task automatic test_first_line();
    use_cfg(1'b0);
    scan(3400, 5, 0, 1'b0);
    vectors++;
    if (errs !== 0) begin
      miscompares++;
      $display("FAIL line0_scan: %0d bad samples, want 0; first %s", errs, first_err);
    end
    vectors++;
    if (hs_first_low !== 2632) begin
      miscompares++;
      $display("FAIL hsync_first_fall: clock %0d, want 2632", hs_first_low);
    end
    vectors++;
    if (probe[0] !== 8'h92) begin
      miscompares++;
      $display("FAIL wall_pixel: rgb=%h, want 92", probe[0]);
    end
  endtask

  task automatic test_frames();
    use_cfg(1'b1);
    mem[5][10] = BLOCK_SNAKE;
    rst_b = 1'b0;
    scan(26400, 20, 10, 1'b1);
    vectors++;
    if (errs !== 0) begin
      miscompares++;
      $display("FAIL frames_scan: %0d bad samples, want 0; first %s", errs, first_err);
    end
    vectors++;
    if (fs_cnt !== 2) begin
      miscompares++;
      $display("FAIL framestart_count: %0d high samples, want 2", fs_cnt);
    end
    vectors++;
    if (fs_first !== 11999) begin
      miscompares++;
      $display("FAIL framestart_first: clock %0d, want 11999", fs_first);
    end
    vectors++;
    if (fs_second - fs_first !== 13200) begin
      miscompares++;
      $display("FAIL framestart_spacing: %0d clocks, want 13200", fs_second - fs_first);
    end
    vectors++;
    if (hs_falls !== 66) begin
      miscompares++;
      $display("FAIL hsync_per_frame: %0d, want 66", hs_falls);
    end
    vectors++;
    if (vs_low !== 400) begin
      miscompares++;
      $display("FAIL vsync_low_clocks: %0d, want 400", vs_low);
    end
    vectors++;
    if (probe[0] !== 8'h1C) begin
      miscompares++;
      $display("FAIL snake_frame0: rgb=%h, want 1c", probe[0]);
    end
    vectors++;
    if (probe[1] !== 8'hE0) begin
      miscompares++;
      $display("FAIL food_frame1: rgb=%h, want e0", probe[1]);
    end
  endtask

  task automatic test_midline_reset();
    use_cfg(1'b1);
    repeat (4060) @(posedge Clock);
    #1;
    vectors++;
    if (rgb_b !== 8'h92) begin
      miscompares++;
      $display("FAIL pre_reset_pixel: rgb=%h, want 92", rgb_b);
    end
    rst_b = 1'b1;
    @(posedge Clock); #1;
    vectors++;
    if ({rgb_b, hs_b, vs_b, fs_b} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL midline_reset_outputs: rgb=%h hs=%b vs=%b fs=%b, want 00 1 1 0", rgb_b, hs_b, vs_b, fs_b);
    end
    vectors++;
    if (gif_b.GridAddrH !== 6'd0 || gif_b.GridAddrV !== 5'd0) begin
      miscompares++;
      $display("FAIL midline_reset_addr: h=%0d v=%0d, want 0 0", gif_b.GridAddrH, gif_b.GridAddrV);
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_illegal_code();
    use_cfg(1'b1);
    mem[3][7] = 3'b111;
    rst_b = 1'b0;
    scan(1400, 14, 6, 1'b0);
    vectors++;
    if (errs !== 0) begin
      miscompares++;
      $display("FAIL restart_scan: %0d bad samples, want 0; first %s", errs, first_err);
    end
    vectors++;
    if (probe[0] !== 8'hE3) begin
      miscompares++;
      $display("FAIL illegal_code_pixel: rgb=%h, want e3", probe[0]);
    end
  endtask

  initial begin
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++)
        mem[r][c] = BLOCK_EMPTY;
    mem[0][0]   = BLOCK_WALL;
    mem[29][39] = BLOCK_FOOD;
    mem[10][14] = BLOCK_WALL;
    test_reset();
    test_first_line();
    test_frames();
    test_midline_reset();
    test_illegal_code();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
